mem_access_arbiter: RTL and testbench

- Sequences the shared single-port 512-word RAM between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Sits between the datapath's PC/MAR/MDR logic and the RAM.
- Owns all RAM strobes, arbitration and wait-state counting.
- Returns a one-cycle done pulse and registered read data to the winning requester.

---
 rtl/mem_access_arbiter_if.sv | 85 ++++++++
 rtl/mem_access_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter_if
//
// Purpose: bundles every requester-side and RAM-side signal of the shared
//          memory arbiter so that the datapath/RAM environment and the
//          arbiter connect through a single port.
//
// Parameters:
//   DATA_WIDTH     word width
//   ADDRESS_WIDTH  word address width
//
// Signals (direction as seen by the arbiter, modport slave):
//   if_req    in   fetch request, level, held until if_done
//   if_addr   in   fetch address
//   if_rdata  out  registered fetch data
//   if_done   out  one-cycle fetch completion pulse
//   ls_req    in   load/store request, level, held until ls_done
//   ls_we     in   1 = write, 0 = read
//   ls_addr   in   load/store address
//   ls_wdata  in   store data
//   ls_rdata  out  registered load data
//   ls_done   out  one-cycle load/store completion pulse
//   mem_addr  out  RAM address
//   mem_wdata out  RAM write data
//   mem_rd    out  RAM read strobe
//   mem_wr    out  RAM write strobe
//   mem_rdata in   RAM read data
//   busy      out  arbiter not idle
//
// Handshake: a requester raises its req level together with its address
// (and, for LS, we/wdata) and keeps req high until it sees its done pulse.
// The arbiter latches address/data at grant, so the request fields only
// need to be stable in the cycle the grant is taken. done is high for
// exactly one cycle per granted transaction; a req still high after the
// arbiter returns to idle is taken as a new request.
//
// modport master: requester/RAM environment (drives reqs and mem_rdata).
// modport slave : the arbiter.
// ---------------------------------------------------------------------------
interface mem_access_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9
);

  logic                     if_req;
  logic [ADDRESS_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0]    if_rdata;
  logic                     if_done;

  logic                     ls_req;
  logic                     ls_we;
  logic [ADDRESS_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0]    ls_wdata;
  logic [DATA_WIDTH-1:0]    ls_rdata;
  logic                     ls_done;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic                     busy;

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_rdata, ls_done,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_rdata, ls_done,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata,
    output busy
  );

endinterface

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Purpose: sequences a shared single-port RAM between an instruction-fetch
//          requester (IF, read-only) and a load/store requester (LS,
//          read/write). Owns the RAM strobes, arbitration and wait-state
//          counting, and returns a one-cycle done pulse plus registered read
//          data to the requester that won.
//
// Parameters:
//   DATA_WIDTH     word width
//   ADDRESS_WIDTH  word address width
//   WAIT_STATES    extra cycles the RAM needs after the strobe (0..15)
//
// Ports:
//   clk          in   system clock, rising edge
//   clr_n        in   asynchronous active-low reset
//   bus          slave modport of mem_access_arbiter_if (requesters + RAM)
//   dbg_state_o  out  current FSM state (IDLE=0, ACCESS=1, COMPLETE=2,
//                     RELEASE=3)
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                           between IF and LS using a last-granted pointer
//                           (reset: LS-last, so IF wins the first tie).
//                           When undefined, LS always beats IF and no
//                           pointer register exists.
//
// Transaction timing (grant taken at edge N):
//   ACCESS   edges N .. N+WAIT_STATES      strobe high WAIT_STATES+1 cycles
//   COMPLETE edge  N+WAIT_STATES+1         done pulse, read data captured
//   RELEASE  edge  N+WAIT_STATES+2         requester drops req
//   IDLE     edge  N+WAIT_STATES+3         earliest next grant one edge later
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int WAIT_STATES   = 1
) (
  input  logic                 clk,
  input  logic                 clr_n,
  mem_access_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // FSM state and transaction context
  state_t                   state_q;
  logic [3:0]               cnt_q;
  logic                     owner_ls_q;
  logic                     we_q;

  // registered outputs
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     rd_q;
  logic                     wr_q;
  logic                     if_done_q;
  logic                     ls_done_q;
  logic [DATA_WIDTH-1:0]    if_rdata_q;
  logic [DATA_WIDTH-1:0]    ls_rdata_q;
  logic                     busy_q;

  // grant decision for the current IDLE cycle
  logic                     any_req_d;
  logic                     pick_ls_d;
  logic                     grant_we_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = LS was granted last, 0 = IF was granted last
  logic                     last_ls_q;
`endif

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  always_comb begin
    any_req_d = bus.if_req | bus.ls_req;
    pick_ls_d = bus.ls_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, grant whichever requester did not win last time; a lone
    // requester wins regardless of the pointer.
    if (bus.if_req && bus.ls_req) begin
      pick_ls_d = ~last_ls_q;
    end
`endif
    // IF is read-only, so the write flag only follows ls_we for LS grants.
    grant_we_d = pick_ls_d & bus.ls_we;
  end

  // -------------------------------------------------------------------------
  // FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      busy_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ls_q  <= 1'b1;
`endif
    end else begin
      // done is a single-cycle pulse; only the ACCESS exit re-arms it
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            owner_ls_q <= pick_ls_d;
            we_q       <= grant_we_d;
            addr_q     <= pick_ls_d ? bus.ls_addr : bus.if_addr;
            // IF carries no store data, so mem_wdata only moves on LS grants
            if (pick_ls_d) begin
              wdata_q <= bus.ls_wdata;
            end
            cnt_q      <= WAIT_LOAD;
            rd_q       <= ~grant_we_d;
            wr_q       <= grant_we_d;
            busy_q     <= 1'b1;
            state_q    <= ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls_q  <= pick_ls_d;
`endif
          end
        end

        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_COMPLETE;
            // Only the owner's read register moves, and only for reads.
            if (!we_q) begin
              if (owner_ls_q) begin
                ls_rdata_q <= bus.mem_rdata;
              end else begin
                if_rdata_q <= bus.mem_rdata;
              end
            end
            if (owner_ls_q) begin
              ls_done_q <= 1'b1;
            end else begin
              if_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_COMPLETE: begin
          state_q <= ST_RELEASE;
        end

        ST_RELEASE: begin
          // Gives the requester a cycle to drop req before IDLE samples it.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.if_done   = if_done_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.busy      = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Two arbiters: dut (WAIT_STATES=1, with a writable RAM model) and dut0
// (WAIT_STATES=0, read-only RAM model). Driver tasks raise requests; the
// expected completion of each transaction is pushed into a per-DUT queue,
// and a negedge monitor pops and compares whenever a done pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int EW = 2 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  mem_access_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus1 ();
  mem_access_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus0 ();
  logic [1:0] dbg1;
  logic [1:0] dbg0;

  mem_access_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WAIT_STATES(1)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus1), .dbg_state_o(dbg1)
  );

  mem_access_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .bus(bus0), .dbg_state_o(dbg0)
  );

  // ---------------- RAM models ----------------
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 9'h010) return 32'h12345678;
    return 32'hA5A50000 | 32'(a);
  endfunction

  bit [DW-1:0] ram1 [512];
  bit          wv1  [512];

  assign bus1.mem_rdata = wv1[bus1.mem_addr] ? ram1[bus1.mem_addr] : init_word(bus1.mem_addr);
  assign bus0.mem_rdata = init_word(bus0.mem_addr);

  always @(posedge clk) begin
    if (bus1.mem_wr) begin
      ram1[bus1.mem_addr] <= bus1.mem_wdata;
      wv1[bus1.mem_addr]  <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp1_q[$];
  logic [EW-1:0] exp0_q[$];
  logic [DW-1:0] sh_if [2];
  logic [DW-1:0] sh_ls [2];
  int if_done_cyc[$];
  int ls_done_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic is_ls, input logic we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] dt);
    return {is_ls, we, a, dt};
  endfunction

  task automatic score(input int d, input logic ifd, input logic lsd,
                       input logic [AW-1:0] ma, input logic [DW-1:0] ifr,
                       input logic [DW-1:0] lsr);
    logic [EW-1:0] e;
    logic have;
    if (!(ifd || lsd)) return;
    chk($sformatf("sb%0d_done_exclusive", d), ifd & lsd, 0);
    have = (d == 1) ? (exp1_q.size() != 0) : (exp0_q.size() != 0);
    chk($sformatf("sb%0d_expected_pending", d), have, 1);
    if (!have) return;
    if (d == 1) e = exp1_q.pop_front();
    else        e = exp0_q.pop_front();
    chk($sformatf("sb%0d_owner_ls", d), lsd, e[EW-1]);
    chk($sformatf("sb%0d_addr", d), ma, e[DW+AW-1:DW]);
    if (!e[EW-2]) begin
      if (e[EW-1]) sh_ls[d] = e[DW-1:0];
      else         sh_if[d] = e[DW-1:0];
    end
    chk($sformatf("sb%0d_if_rdata", d), ifr, sh_if[d]);
    chk($sformatf("sb%0d_ls_rdata", d), lsr, sh_ls[d]);
  endtask

  always @(negedge clk) begin
    if (!clr_n) begin
      sh_if[0] = '0; sh_if[1] = '0;
      sh_ls[0] = '0; sh_ls[1] = '0;
    end else begin
      score(1, bus1.if_done, bus1.ls_done, bus1.mem_addr, bus1.if_rdata, bus1.ls_rdata);
      score(0, bus0.if_done, bus0.ls_done, bus0.mem_addr, bus0.if_rdata, bus0.ls_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_if(input int d, input logic r, input logic [AW-1:0] a);
    if (d == 1) begin bus1.if_req = r; bus1.if_addr = a; end
    else        begin bus0.if_req = r; bus0.if_addr = a; end
  endtask

  // Waits (bounded) for the chosen done pulse, counting strobe cycles seen.
  task automatic wait_done(input int d, input logic is_ls, output logic ok,
                           output int rdc, output int wrc);
    ok = 1'b0; rdc = 0; wrc = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (d == 1) begin
        ok = is_ls ? bus1.ls_done : bus1.if_done;
        rdc += int'(bus1.mem_rd); wrc += int'(bus1.mem_wr);
      end else begin
        ok = is_ls ? bus0.ls_done : bus0.if_done;
        rdc += int'(bus0.mem_rd); wrc += int'(bus0.mem_wr);
      end
    end
    chk($sformatf("done_seen_d%0d_ls%0d", d, is_ls), ok, 1);
  endtask

  task automatic if_run(input int d, input int n, input logic [AW-1:0] a0,
                        output int rdc, output int wrc);
    logic ok;
    rdc = 0; wrc = 0;
    for (int k = 0; k < n; k++) begin
      set_if(d, 1'b1, a0 + AW'(k));
      wait_done(d, 1'b0, ok, rdc, wrc);
      if (ok) if_done_cyc.push_back(cyc);
    end
    set_if(d, 1'b0, a0);
  endtask

  task automatic ls_run(input int n, input logic [AW-1:0] a0, input logic we,
                        input logic [DW-1:0] wd, output int rdc, output int wrc);
    logic ok;
    rdc = 0; wrc = 0;
    for (int k = 0; k < n; k++) begin
      bus1.ls_we = we; bus1.ls_addr = a0 + AW'(k); bus1.ls_wdata = wd; bus1.ls_req = 1'b1;
      wait_done(1, 1'b1, ok, rdc, wrc);
      if (ok) ls_done_cyc.push_back(cyc);
    end
    bus1.ls_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int r;
    int rc, wc, rc2, wc2;

    bus1.if_req = 0; bus1.if_addr = '0; bus1.ls_req = 0; bus1.ls_we = 0;
    bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus0.if_req = 0; bus0.if_addr = '0; bus0.ls_req = 0; bus0.ls_we = 0;
    bus0.ls_addr = '0; bus0.ls_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", dbg1, 0);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_mem_rd", bus1.mem_rd, 0);
    chk("rst_mem_wr", bus1.mem_wr, 0);
    chk("rst_mem_addr", bus1.mem_addr, 0);
    chk("rst_mem_wdata", bus1.mem_wdata, 0);
    chk("rst_if_rdata", bus1.if_rdata, 0);
    chk("rst_ls_rdata", bus1.ls_rdata, 0);
    chk("rst_if_done", bus1.if_done, 0);
    chk("rst_ls_done", bus1.ls_done, 0);
    chk("rst0_busy", bus0.busy, 0);
    clr_n = 1'b1;

    // IF read of 0x010 with explicit cycle-by-cycle timing
    @(posedge clk); #1;
    exp1_q.push_back(mk(1'b0, 1'b0, 9'h010, 32'h12345678));
    bus1.if_addr = 9'h010; bus1.if_req = 1'b1;
    @(posedge clk); #1;
    chk("t1_grant_state", dbg1, 1);
    chk("t1_rd_c0", bus1.mem_rd, 1);
    chk("t1_wr_c0", bus1.mem_wr, 0);
    chk("t1_addr", bus1.mem_addr, 9'h010);
    chk("t1_busy", bus1.busy, 1);
    @(posedge clk); #1;
    chk("t1_rd_c1", bus1.mem_rd, 1);
    chk("t1_done_early", bus1.if_done, 0);
    @(posedge clk); #1;
    chk("t1_rd_off", bus1.mem_rd, 0);
    chk("t1_if_done", bus1.if_done, 1);
    chk("t1_if_rdata", bus1.if_rdata, 32'h12345678);
    chk("t1_ls_rdata", bus1.ls_rdata, 0);
    bus1.if_req = 1'b0;
    @(posedge clk); #1;
    chk("t1_done_pulse", bus1.if_done, 0);
    chk("t1_release_busy", bus1.busy, 1);
    chk("t1_addr_hold", bus1.mem_addr, 9'h010);
    @(posedge clk); #1;
    chk("t1_idle_busy", bus1.busy, 0);
    chk("t1_idle_addr", bus1.mem_addr, 9'h010);

    // LS write then read of 0x1FF
    exp1_q.push_back(mk(1'b1, 1'b1, 9'h1FF, 32'h0));
    ls_run(1, 9'h1FF, 1'b1, 32'hDEADBEEF, rc, wc);
    chk("t2_wr_cycles", wc, 2);
    chk("t2_wr_no_rd", rc, 0);
    chk("t2_wdata", bus1.mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h1FF, 32'hDEADBEEF));
    ls_run(1, 9'h1FF, 1'b0, 32'h0, rc, wc);
    chk("t2_rd_cycles", rc, 2);
    chk("t2_rd_no_wr", wc, 0);
    chk("t2_ls_rdata", bus1.ls_rdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of an LS write
    bus1.ls_we = 1'b1; bus1.ls_addr = 9'h055; bus1.ls_wdata = 32'hCAFEF00D; bus1.ls_req = 1'b1;
    @(posedge clk); #1;
    chk("t3_wr_before", bus1.mem_wr, 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("t3_wr_async_drop", bus1.mem_wr, 0);
    chk("t3_busy", bus1.busy, 0);
    chk("t3_no_done", bus1.ls_done, 0);
    bus1.ls_req = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("t3_idle_after", dbg1, 0);
    exp1_q.push_back(mk(1'b1, 1'b1, 9'h055, 32'h0));
    ls_run(1, 9'h055, 1'b1, 32'hCAFEF00D, rc, wc);
    chk("t3_reissue_wr", wc, 2);
    @(posedge clk); #1;
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h055, 32'hCAFEF00D));
    ls_run(1, 9'h055, 1'b0, 32'h0, rc, wc);
    repeat (2) @(posedge clk);
    #1;

    // simultaneous requests, each held for two transactions
    if_done_cyc.delete();
    ls_done_cyc.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp1_q.push_back(mk(1'b0, 1'b0, 9'h020, init_word(9'h020)));
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h100, init_word(9'h100)));
    exp1_q.push_back(mk(1'b0, 1'b0, 9'h021, init_word(9'h021)));
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h101, init_word(9'h101)));
`else
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h100, init_word(9'h100)));
    exp1_q.push_back(mk(1'b1, 1'b0, 9'h101, init_word(9'h101)));
    exp1_q.push_back(mk(1'b0, 1'b0, 9'h020, init_word(9'h020)));
    exp1_q.push_back(mk(1'b0, 1'b0, 9'h021, init_word(9'h021)));
`endif
    r = cyc;
    fork
      if_run(1, 2, 9'h020, rc, wc);
      ls_run(2, 9'h100, 1'b0, 32'h0, rc2, wc2);
    join
    chk("t4_if_count", if_done_cyc.size(), 2);
    chk("t4_ls_count", ls_done_cyc.size(), 2);
    if (if_done_cyc.size() == 2 && ls_done_cyc.size() == 2) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("t4_if0_cyc", if_done_cyc[0] - r, 3);
      chk("t4_ls0_cyc", ls_done_cyc[0] - r, 8);
      chk("t4_if1_cyc", if_done_cyc[1] - r, 13);
      chk("t4_ls1_cyc", ls_done_cyc[1] - r, 18);
`else
      chk("t4_ls0_cyc", ls_done_cyc[0] - r, 3);
      chk("t4_ls1_cyc", ls_done_cyc[1] - r, 8);
      chk("t4_if0_cyc", if_done_cyc[0] - r, 13);
      chk("t4_if1_cyc", if_done_cyc[1] - r, 18);
`endif
    end
    repeat (2) @(posedge clk);
    #1;

    // WAIT_STATES=0: back-to-back IF reads of 0..3 on dut0
    if_done_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      exp0_q.push_back(mk(1'b0, 1'b0, AW'(k), init_word(AW'(k))));
    end
    r = cyc;
    if_run(0, 4, 9'h000, rc, wc);
    chk("t5_rd_cycles", rc, 1);
    chk("t5_count", if_done_cyc.size(), 4);
    if (if_done_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("t5_done%0d_cyc", k), if_done_cyc[k] - r, 2 + 4 * k);
      end
    end

    repeat (6) @(posedge clk);
    #1;
    chk("sb1_drained", exp1_q.size(), 0);
    chk("sb0_drained", exp0_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
